// File: rtl/updown_cntr_param_pkg.sv
// Shared definitions for the parametrised up/down counter family:
// mode constants, per-cycle operation encoding and the parameter legality rule.
package updown_cntr_param_pkg;

  localparam int CNTR_WRAP = 0;
  localparam int CNTR_SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } cntr_op_e;

  // Reused by future pointer counters so every instance rejects the same bad shapes.
  function automatic bit cntr_params_ok(int width, int max_val, int step, int sat);
    longint lim;
    if (width < 1 || width > 30) return 1'b0;
    lim = (longint'(1) << width) - 1;
    return (max_val >= 1) && (longint'(max_val) <= lim) &&
           (step >= 1) && (step <= max_val) &&
           (sat == CNTR_WRAP || sat == CNTR_SAT);
  endfunction

endpackage

// File: rtl/updown_cntr_param_if.sv
// Control/status bundle between a counter and its owner (heap/FIFO control).
interface updown_cntr_param_if #(parameter int WIDTH = 8);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             inc;
  logic             dec;
  logic             clr_flags;
  logic [WIDTH-1:0] q;
  logic             at_max;
  logic             at_zero;
  logic             tc;
  logic             ovf;
  logic             unf;
  logic             load_err;

  modport master (
    output load, load_val, inc, dec, clr_flags,
    input  q, at_max, at_zero, tc, ovf, unf, load_err
  );

  modport slave (
    input  load, load_val, inc, dec, clr_flags,
    output q, at_max, at_zero, tc, ovf, unf, load_err
  );
endinterface

// File: rtl/updown_cntr_param_next_val.sv
// Purely combinational next-count computation: priority decode, boundary
// crossing detection and wrap/clamp, all in WIDTH+1 bits before truncation.
module cntr_next_val
  import updown_cntr_param_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int STEP     = 1,
  parameter int SATURATE = CNTR_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_q,
  output logic             cross_hi,
  output logic             cross_lo,
  output logic             load_bad
);

  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);

  cntr_op_e       op;
  logic [WIDTH:0] q_x;
  logic [WIDTH:0] up;
  logic [WIDTH:0] up_wrap;
  logic [WIDTH:0] dn;
  logic [WIDTH:0] dn_wrap;

  assign q_x     = {1'b0, q};
  assign up      = q_x + STEP_X;
  assign up_wrap = up - MAX_X - ONE_X;
  assign dn      = q_x - STEP_X;
  // q < STEP <= MAX_VAL here, so q + MAX_VAL + 1 never exceeds WIDTH+1 bits.
  assign dn_wrap = q_x + MAX_X + ONE_X - STEP_X;

  always_comb begin
    op = OP_HOLD;
    if (load)              op = OP_LOAD;
    else if (inc && !dec)  op = OP_INC;
    else if (dec && !inc)  op = OP_DEC;
  end

  always_comb begin
    next_q   = q;
    cross_hi = 1'b0;
    cross_lo = 1'b0;
    load_bad = 1'b0;
    case (op)
      OP_LOAD: begin
        if ({1'b0, load_val} > MAX_X) begin
          next_q   = MAX_Q;
          load_bad = 1'b1;
        end else begin
          next_q = load_val;
        end
      end
      OP_INC: begin
        if (up > MAX_X) begin
          cross_hi = 1'b1;
          next_q   = (SATURATE == CNTR_SAT) ? MAX_Q : WIDTH'(up_wrap);
        end else begin
          next_q = WIDTH'(up);
        end
      end
      OP_DEC: begin
        if (q_x >= STEP_X) begin
          next_q = WIDTH'(dn);
        end else begin
          cross_lo = 1'b1;
          next_q   = (SATURATE == CNTR_SAT) ? '0 : WIDTH'(dn_wrap);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/updown_cntr_param.sv
// Parametrised up/down size/pointer counter: holds q, the terminal-count pulse
// and sticky ovf/unf/load_err, with at_max/at_zero decoded straight from q.
module updown_cntr_param
  import updown_cntr_param_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 255,
  parameter int STEP     = 1,
  parameter int SATURATE = CNTR_WRAP
) (
  input  logic              clk,
  input  logic              reset,
  updown_cntr_param_if.slave bus
);

  generate
    if (!cntr_params_ok(WIDTH, MAX_VAL, STEP, SATURATE)) begin : g_bad_params
      $error("updown_cntr_param: illegal WIDTH/MAX_VAL/STEP/SATURATE combination");
    end
  endgenerate

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_q;
  logic             cross_hi;
  logic             cross_lo;
  logic             load_bad;
  logic             tc_r;
  logic             ovf_r;
  logic             unf_r;
  logic             load_err_r;

  cntr_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (q_r),
    .inc      (bus.inc),
    .dec      (bus.dec),
    .load     (bus.load),
    .load_val (bus.load_val),
    .next_q   (next_q),
    .cross_hi (cross_hi),
    .cross_lo (cross_lo),
    .load_bad (load_bad)
  );

  // A fresh event in the same cycle as clr_flags leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r        <= '0;
      tc_r       <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= next_q;
      tc_r       <= cross_hi | cross_lo;
      ovf_r      <= (ovf_r      & ~bus.clr_flags) | cross_hi;
      unf_r      <= (unf_r      & ~bus.clr_flags) | cross_lo;
      load_err_r <= (load_err_r & ~bus.clr_flags) | load_bad;
    end
  end

  assign bus.q        = q_r;
  assign bus.at_max   = (q_r == WIDTH'(MAX_VAL));
  assign bus.at_zero  = (q_r == '0);
  assign bus.tc       = tc_r;
  assign bus.ovf      = ovf_r;
  assign bus.unf      = unf_r;
  assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_updown_cntr_param.sv
// Three counter shapes driven in lockstep; a queue scoreboard checks every
// cycle against an integer reference model, plus directed scenario checks.
module tb_updown_cntr_param;
  import updown_cntr_param_pkg::*;

  typedef struct {
    int q;
    bit tc, ovf, unf, lerr, amax, azero;
  } exp_t;

  localparam int NDUT = 3;
  int P_W[NDUT]    = '{8, 4, 4};
  int P_MAX[NDUT]  = '{255, 9, 9};
  int P_STEP[NDUT] = '{1, 3, 3};
  int P_SAT[NDUT]  = '{0, 0, 1};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_cntr_param_if #(.WIDTH(8)) if0 ();
  updown_cntr_param_if #(.WIDTH(4)) if1 ();
  updown_cntr_param_if #(.WIDTH(4)) if2 ();

  updown_cntr_param #(.WIDTH(8), .MAX_VAL(255), .STEP(1), .SATURATE(CNTR_WRAP))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  updown_cntr_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(CNTR_WRAP))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  updown_cntr_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(CNTR_SAT))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  int   checks   = 0;
  int   failures = 0;
  exp_t st[NDUT];
  exp_t sb0[$], sb1[$], sb2[$];

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: counter value as a plain integer, rules applied directly.
  function automatic exp_t model(int k, exp_t s, bit r, bit ld, int lv, bit i, bit d, bit c);
    exp_t n;
    int mx, stp, v;
    bit hi, lo, bad;
    n = s; hi = 0; lo = 0; bad = 0;
    mx = P_MAX[k]; stp = P_STEP[k];
    v = lv % (1 << P_W[k]);
    if (r) begin
      n.q = 0; n.tc = 0; n.ovf = 0; n.unf = 0; n.lerr = 0;
    end else begin
      if (ld) begin
        if (v > mx) begin n.q = mx; bad = 1; end
        else n.q = v;
      end else if (i && !d) begin
        if (s.q + stp > mx) begin
          hi = 1;
          n.q = P_SAT[k] ? mx : s.q + stp - (mx + 1);
        end else n.q = s.q + stp;
      end else if (d && !i) begin
        if (s.q < stp) begin
          lo = 1;
          n.q = P_SAT[k] ? 0 : s.q + (mx + 1) - stp;
        end else n.q = s.q - stp;
      end
      n.tc   = hi || lo;
      n.ovf  = (s.ovf && !c) || hi;
      n.unf  = (s.unf && !c) || lo;
      n.lerr = (s.lerr && !c) || bad;
    end
    n.amax  = (n.q == mx);
    n.azero = (n.q == 0);
    return n;
  endfunction

  task automatic drive(bit r, bit ld, int lv, bit i, bit d, bit c);
    @(negedge clk);
    reset = r;
    if0.load = ld; if0.load_val = 8'(lv); if0.inc = i; if0.dec = d; if0.clr_flags = c;
    if1.load = ld; if1.load_val = 4'(lv); if1.inc = i; if1.dec = d; if1.clr_flags = c;
    if2.load = ld; if2.load_val = 4'(lv); if2.inc = i; if2.dec = d; if2.clr_flags = c;
    for (int k = 0; k < NDUT; k++) st[k] = model(k, st[k], r, ld, lv, i, d, c);
    sb0.push_back(st[0]);
    sb1.push_back(st[1]);
    sb2.push_back(st[2]);
  endtask

  // One cycle, then let the edge settle so directed checks can read outputs.
  task automatic step(bit r, bit ld, int lv, bit i, bit d, bit c);
    drive(r, ld, lv, i, d, c);
    @(posedge clk);
    #2;
  endtask

  task automatic cmp(string tag, exp_t e, int q, bit tc, bit ovf, bit unf, bit lerr,
                     bit amax, bit azero);
    chk({tag, ".q"}, q, e.q);
    chk({tag, ".tc"}, int'(tc), int'(e.tc));
    chk({tag, ".ovf"}, int'(ovf), int'(e.ovf));
    chk({tag, ".unf"}, int'(unf), int'(e.unf));
    chk({tag, ".load_err"}, int'(lerr), int'(e.lerr));
    chk({tag, ".at_max"}, int'(amax), int'(e.amax));
    chk({tag, ".at_zero"}, int'(azero), int'(e.azero));
  endtask

  // Scoreboard monitor: the DUT presents a new count after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        cmp("sb0", e, int'(if0.q), if0.tc, if0.ovf, if0.unf, if0.load_err, if0.at_max, if0.at_zero);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        cmp("sb1", e, int'(if1.q), if1.tc, if1.ovf, if1.unf, if1.load_err, if1.at_max, if1.at_zero);
      end
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        cmp("sb2", e, int'(if2.q), if2.tc, if2.ovf, if2.unf, if2.load_err, if2.at_max, if2.at_zero);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lim;
    reset = 1'b1;
    if0.load = 0; if0.load_val = '0; if0.inc = 0; if0.dec = 0; if0.clr_flags = 0;
    if1.load = 0; if1.load_val = '0; if1.inc = 0; if1.dec = 0; if1.clr_flags = 0;
    if2.load = 0; if2.load_val = '0; if2.inc = 0; if2.dec = 0; if2.clr_flags = 0;
    for (int k = 0; k < NDUT; k++) st[k] = '{default: 0};

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    chk("rst.q", int'(if0.q), 0);
    chk("rst.at_zero", int'(if0.at_zero), 1);
    chk("rst.at_max", int'(if0.at_max), 0);
    chk("rst.flags", int'({if0.tc, if0.ovf, if0.unf, if0.load_err}), 0);

    // 300 incs on the default 8-bit wrap counter
    for (int n = 1; n <= 300; n++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("t1.tc", int'(if0.tc), (n == 256) ? 1 : 0);
      if (n == 256) chk("t1.wrap_q", int'(if0.q), 0);
    end
    chk("t1.q_end", int'(if0.q), 44);
    chk("t1.ovf", int'(if0.ovf), 1);

    // Max 9, step 3: wrap vs saturate
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 8, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t2.q_inc", int'(if1.q), 1);
    chk("t2.ovf", int'(if1.ovf), 1);
    chk("t2.tc", int'(if1.tc), 1);
    chk("t3.q_inc", int'(if2.q), 9);
    chk("t3.at_max", int'(if2.at_max), 1);
    chk("t3.ovf", int'(if2.ovf), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("t2.q_dec", int'(if1.q), 8);
    chk("t2.unf", int'(if1.unf), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t2.clr", int'({if1.ovf, if1.unf}), 0);

    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 8, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3.q_hold", int'(if2.q), 9);
    chk("t3.tc_hold", int'(if2.tc), 1);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("t3.q_dec", int'(if2.q), 0);
    chk("t3.at_zero", int'(if2.at_zero), 1);
    chk("t3.unf", int'(if2.unf), 1);

    // Priority
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("t4.incdec_q", int'(if0.q), 5);
    chk("t4.incdec_tc", int'(if0.tc), 0);
    step(0, 1, 7, 1, 0, 0);
    chk("t4.load_inc", int'(if0.q), 7);
    step(1, 1, 3, 0, 0, 0);
    chk("t4.rst_load", int'(if0.q), 0);

    // Bad load
    step(0, 1, 12, 0, 0, 0);
    chk("t5.q", int'(if1.q), 9);
    chk("t5.load_err", int'(if1.load_err), 1);
    step(0, 1, 12, 0, 0, 1);
    chk("t5.set_wins", int'(if1.load_err), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("t5.cleared", int'(if1.load_err), 0);

    // Reset mid-count
    step(0, 1, 255, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 200, 0, 0, 0);
    chk("t6.q_pre", int'(if0.q), 200);
    step(1, 0, 0, 1, 0, 0);
    chk("t6.q_rst", int'(if0.q), 0);
    chk("t6.flags", int'({if0.tc, if0.ovf, if0.unf, if0.load_err}), 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6.resume", int'(if0.q), 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ($urandom_range(0, 9) == 0));
    end

    lim = 0;
    while ((sb0.size() + sb1.size() + sb2.size()) != 0 && lim < 10) begin
      @(posedge clk);
      #2;
      lim++;
    end
    chk("drain", sb0.size() + sb1.size() + sb2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
